// File: rtl/down_timer.sv
// Loadable down-counter with prescaled tick, one-cycle terminal-count pulse,
// and one-shot or auto-reload operation.
module down_timer #(
    parameter int W  = 8,
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          sclr,
    input  logic          start,
    input  logic          stop,
    input  logic          en,
    input  logic [W-1:0]  load_val,
    input  logic [PW-1:0] prescale,
    input  logic          auto_reload,
    output logic [W-1:0]  q,
    output logic          busy,
    output logic          tc,
    output logic          done
);

    // state | meaning
    // IDLE  | stopped or after reset, q holds
    // RUN   | counting down on prescaled ticks
    // DONE  | one-shot finished, q=0, done held
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [PW-1:0] pc;
    logic [W-1:0]  reload_r;
    logic [PW-1:0] prescale_r;
    logic          mode_r;

    always_ff @(posedge clk) begin
        if (sclr) begin
            state      <= IDLE;
            q          <= '0;
            pc         <= '0;
            reload_r   <= '0;
            prescale_r <= '0;
            mode_r     <= 1'b0;
            busy       <= 1'b0;
            tc         <= 1'b0;
            done       <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (start) begin
                q          <= load_val;
                reload_r   <= load_val;
                prescale_r <= prescale;
                mode_r     <= auto_reload;
                pc         <= '0;
                if (load_val != '0) begin
                    state <= RUN;
                    busy  <= 1'b1;
                    done  <= 1'b0;
                end else begin
                    // zero-length run completes immediately, mode is irrelevant
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    tc    <= 1'b1;
                end
            end else if (stop) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b0;
                pc    <= '0;
            end else if (state == RUN && en) begin
                if (pc != prescale_r) begin
                    pc <= pc + PW'(1);
                end else begin
                    pc <= '0;
                    if (q > W'(1)) begin
                        q <= q - W'(1);
                    end else begin
                        tc <= 1'b1;
                        if (mode_r) begin
                            q <= reload_r;
                        end else begin
                            q     <= '0;
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_down_timer.sv
// Directed bench for down_timer: outputs checked 1 time unit after each
// rising edge against hand-computed values.
module tb_down_timer;

    logic       clk;
    logic       sclr;
    logic       start;
    logic       stop;
    logic       en;
    logic [7:0] load_val;
    logic [3:0] prescale;
    logic       auto_reload;
    logic [7:0] q;
    logic       busy;
    logic       tc;
    logic       done;

    int total = 0;
    int bad   = 0;

    down_timer #(.W(8), .PW(4)) dut (
        .clk(clk),
        .sclr(sclr),
        .start(start),
        .stop(stop),
        .en(en),
        .load_val(load_val),
        .prescale(prescale),
        .auto_reload(auto_reload),
        .q(q),
        .busy(busy),
        .tc(tc),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int eq, input int ebusy,
                           input int etc, input int edone);
        chk({tag, ".q"},    32'(q),    32'(eq));
        chk({tag, ".busy"}, 32'(busy), 32'(ebusy));
        chk({tag, ".tc"},   32'(tc),   32'(etc));
        chk({tag, ".done"}, 32'(done), 32'(edone));
    endtask

    initial begin
        int tc_edge;
        sclr = 1'b1; start = 1'b1; stop = 1'b0; en = 1'b1;
        load_val = 8'd9; prescale = 4'd0; auto_reload = 1'b0;

        // reset holds off a simultaneous start
        step();
        step();
        chk_all("reset", 0, 0, 0, 0);
        sclr = 1'b0; start = 1'b0;
        step();
        chk_all("idle", 0, 0, 0, 0);

        // one-shot, L=5, P=0
        load_val = 8'd5; prescale = 4'd0; auto_reload = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        chk_all("os.e0", 5, 1, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk_all("os.run", 5 - k, (k < 5) ? 1 : 0, (k == 5) ? 1 : 0, (k == 5) ? 1 : 0);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            chk_all("os.hold", 0, 0, 0, 1);
        end

        // auto-reload, L=3, P=2; mid-run input changes must not matter
        load_val = 8'd3; prescale = 4'd2; auto_reload = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        chk_all("ar.e0", 3, 1, 0, 0);
        load_val = 8'd100; prescale = 4'd0; auto_reload = 1'b0;
        for (int e = 1; e <= 28; e++) begin
            step();
            chk_all("ar.run", 3 - ((e / 3) % 3), 1, (e % 9 == 0) ? 1 : 0, 0);
        end

        // pause: L=10, P=0, en low for 4 cycles after edge 3
        load_val = 8'd10; prescale = 4'd0; auto_reload = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int e = 1; e <= 3; e++) step();
        chk_all("pause.pre", 7, 1, 0, 0);
        en = 1'b0;
        for (int e = 0; e < 4; e++) begin
            step();
            chk_all("pause.frz", 7, 1, 0, 0);
        end
        en = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step();
            chk_all("pause.run", 7 - i, (i < 7) ? 1 : 0, (i == 7) ? 1 : 0, (i == 7) ? 1 : 0);
        end

        // stop at q=6
        load_val = 8'd10; start = 1'b1;
        step();
        start = 1'b0;
        for (int e = 1; e <= 4; e++) step();
        chk_all("stop.pre", 6, 1, 0, 0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk_all("stop.now", 6, 0, 0, 0);
        for (int e = 0; e < 3; e++) begin
            step();
            chk_all("stop.idle", 6, 0, 0, 0);
        end

        // restart mid-prescale: pc must restart from 0
        load_val = 8'd4; prescale = 4'd1; start = 1'b1;
        step();
        start = 1'b0;
        for (int e = 1; e <= 5; e++) step();
        chk_all("rs.pre", 2, 1, 0, 0);
        load_val = 8'd7; start = 1'b1;
        step();
        start = 1'b0;
        chk_all("rs.e0", 7, 1, 0, 0);
        for (int e = 1; e <= 14; e++) begin
            step();
            chk_all("rs.run", 7 - e / 2, (e < 14) ? 1 : 0, (e == 14) ? 1 : 0, (e == 14) ? 1 : 0);
        end

        // start and stop together: start wins
        load_val = 8'd3; prescale = 4'd0; start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        chk_all("ss", 3, 1, 0, 0);
        step();
        chk_all("ss.run", 2, 1, 0, 0);

        // sclr and start together mid-run: reset wins
        sclr = 1'b1; start = 1'b1; load_val = 8'd9;
        step();
        sclr = 1'b0; start = 1'b0;
        chk_all("rst.run", 0, 0, 0, 0);
        step();
        chk_all("rst.idle", 0, 0, 0, 0);

        // zero-length run, auto_reload ignored
        load_val = 8'd0; auto_reload = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        chk_all("zero.e0", 0, 0, 1, 1);
        step();
        chk_all("zero.e1", 0, 0, 0, 1);
        step();
        chk_all("zero.e2", 0, 0, 0, 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk_all("zero.stop", 0, 0, 0, 0);

        // max load and max prescale: tc after 255*16 clocks
        load_val = 8'd255; prescale = 4'd15; auto_reload = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        chk_all("max.e0", 255, 1, 0, 0);
        for (int e = 1; e <= 16; e++) step();
        chk_all("max.e16", 254, 1, 0, 0);
        tc_edge = -1;
        for (int e = 17; e <= 5000; e++) begin
            step();
            if (tc) begin
                tc_edge = e;
                break;
            end
        end
        chk("max.tc_edge", 32'(tc_edge), 32'd4080);
        chk_all("max.end", 0, 0, 1, 1);
        step();
        chk_all("max.after", 0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
